// File: rtl/sat_mul_pkg.sv
// Shared types and helpers for the saturating shift-and-add multiplier.
package sat_mul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    // Widest accumulator the clamp helper handles; A_WIDTH+B_WIDTH and
    // OUT_WIDTH of any instance must not exceed this.
    localparam int unsigned CLAMP_W = 128;

    // Returns {sat, value}: sat is set when acc has any bit at or above
    // out_w, value is acc limited to out_w bits (all-ones when saturated).
    function automatic logic [CLAMP_W:0] sat_clamp(
        input logic [CLAMP_W-1:0] acc,
        input int unsigned        out_w
    );
        logic [CLAMP_W-1:0] mask;
        logic               sat;
        mask = '1;
        if (out_w < CLAMP_W) begin
            mask = ~({CLAMP_W{1'b1}} << out_w);
        end
        sat = |(acc & ~mask);
        return {sat, (sat ? mask : (acc & mask))};
    endfunction

endpackage

// File: rtl/sat_shift_add_mul.sv
// Sequential unsigned multiplier, one multiplier bit per cycle, with the
// product clamped to OUT_WIDTH bits and valid/ready on both sides.
module sat_shift_add_mul
    import sat_mul_pkg::*;
#(
    parameter int unsigned A_WIDTH   = 32,
    parameter int unsigned B_WIDTH   = 8,
    parameter int unsigned OUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 din_valid,
    output logic                 din_ready,
    input  logic [A_WIDTH-1:0]   din_a,
    input  logic [B_WIDTH-1:0]   din_b,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic [OUT_WIDTH-1:0] dout,
    output logic                 dout_sat
);

    localparam int unsigned ACC_W = A_WIDTH + B_WIDTH;
    localparam int unsigned CNT_W = $clog2(B_WIDTH + 1);

    state_t               state_q,    state_d;
    logic [ACC_W-1:0]     a_sh_q,     a_sh_d;
    logic [B_WIDTH-1:0]   b_sh_q,     b_sh_d;
    logic [ACC_W-1:0]     acc_q,      acc_d;
    logic [CNT_W-1:0]     cnt_q,      cnt_d;
    logic [OUT_WIDTH-1:0] dout_q,     dout_d;
    logic                 dout_sat_q, dout_sat_d;

    logic [ACC_W-1:0]     acc_step;
    logic [CLAMP_W:0]     clamp_res;
    logic                 clamp_unused;

    // State and datapath registers; reset wins over any handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            dout_q     <= '0;
            dout_sat_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_sh_q     <= a_sh_d;
            b_sh_q     <= b_sh_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            dout_q     <= dout_d;
            dout_sat_q <= dout_sat_d;
        end
    end

    // Next-state and datapath update; the clamp sees the accumulator after
    // the current step so the final iteration lands in dout directly.
    always_comb begin
        state_d    = state_q;
        a_sh_d     = a_sh_q;
        b_sh_d     = b_sh_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        dout_d     = dout_q;
        dout_sat_d = dout_sat_q;

        acc_step     = acc_q + (b_sh_q[0] ? a_sh_q : '0);
        clamp_res    = sat_clamp(CLAMP_W'(acc_step), OUT_WIDTH);
        clamp_unused = |clamp_res[CLAMP_W-1:OUT_WIDTH];

        unique case (state_q)
            IDLE: begin
                if (din_valid) begin
                    a_sh_d  = ACC_W'(din_a);
                    b_sh_d  = din_b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                acc_d  = acc_step;
                a_sh_d = a_sh_q << 1;
                b_sh_d = b_sh_q >> 1;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(B_WIDTH - 1)) begin
                    dout_d     = clamp_res[OUT_WIDTH-1:0];
                    dout_sat_d = clamp_res[CLAMP_W];
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (dout_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake outputs decode registered state only.
    always_comb begin
        din_ready  = (state_q == IDLE);
        dout_valid = (state_q == DONE);
        dout       = dout_q;
        dout_sat   = dout_sat_q;
    end

endmodule

// File: doc/sat_shift_add_mul.md
# sat_shift_add_mul

- Sequential unsigned multiplier with saturating output.
- Computes dout = min(din_a × din_b, 2^OUT_WIDTH − 1) one multiplier bit per cycle: shift-and-add, B_WIDTH iterations.
- Is the scale-up counterpart of the power-of-two rounding divider; re-expands reduced-precision values by an arbitrary runtime factor.
- Valid/ready handshakes on both sides; sits between a producer and a consumer that can each stall.

## Interface

Parameters:
- A_WIDTH, 32, width of multiplicand din_a
- B_WIDTH, 8, width of multiplier din_b; also the iteration count
- OUT_WIDTH, 32, width of dout; product clamps to this width

Ports:
- clk  input  1  rising-edge clock; one clock domain
- reset  input  1  synchronous, active-high reset
- din_valid  input  1  operands present
- din_ready  output  1  block can accept operands
- din_a  input  A_WIDTH  unsigned multiplicand
- din_b  input  B_WIDTH  unsigned multiplier
- dout_valid  output  1  result present
- dout_ready  input  1  consumer takes result
- dout  output  OUT_WIDTH  saturated product
- dout_sat  output  1  high when the true product exceeded 2^OUT_WIDTH − 1

## Operation

States:
- IDLE: din_ready=1. If din_valid, perform the following and go to BUSY.
  - Latch a_sh ← zero-extended din_a, width A_WIDTH+B_WIDTH.
  - Latch b_sh ← din_b.
  - Clear acc.
  - Clear cnt.
- BUSY: din_ready=0. Each cycle:
  - If b_sh[0], acc ← acc + a_sh.
  - a_sh ← a_sh << 1.
  - b_sh ← b_sh >> 1.
  - cnt ← cnt + 1.
  - When cnt = B_WIDTH−1, the step still executes; then register dout/dout_sat and go to DONE.
- DONE: dout_valid=1.
  - dout and dout_sat are held stable until dout_ready=1, then go to IDLE.
  - din_ready stays 0 in DONE; there is no same-cycle accept on the output handshake.

Arithmetic rules:
- acc is A_WIDTH+B_WIDTH bits wide, so it cannot overflow.
- dout_sat = |acc[A_WIDTH+B_WIDTH−1:OUT_WIDTH]. This is 0 when OUT_WIDTH ≥ A_WIDTH+B_WIDTH.
- dout = dout_sat ? all-ones : acc[OUT_WIDTH−1:0].
- All iterations always run; there is no early exit when b_sh becomes 0, so latency is constant.
- cnt is $clog2(B_WIDTH+1) bits.

Boundary conditions:
- din_valid while BUSY or DONE is ignored and operands are not sampled. The producer must hold them until it sees din_ready.
- din_b=0 or din_a=0 gives dout=0, dout_sat=0 after full latency.
- Maximum operands (all ones) give dout=all-ones, dout_sat=1 for defaults.
- Reset in any state: next cycle state=IDLE, handshakes in the reset cycle are ignored, and no result is emitted for the aborted operation.

## Timing

Reset values:
- state=IDLE, dout_valid=0, dout=0, dout_sat=0.
- acc, a_sh, b_sh and cnt are 0.
- din_ready=1 from the first cycle after reset deasserts.

Latency and throughput:
- The accept edge is k.
- dout_valid is first high in the cycle after edge k+B_WIDTH, i.e. B_WIDTH+1 cycles after accept.
- Minimum issue interval is B_WIDTH+2 cycles with dout_ready tied high (accept, B_WIDTH busy, 1 done).

Output behaviour:
- din_ready and dout_valid are decoded from registered state only, with no combinational path from inputs.
- dout and dout_sat are registered.

## Structure

- Package sat_mul_pkg holds:
  - typedef enum logic [1:0] state_t {IDLE, BUSY, DONE};
  - function sat_clamp(acc) returning {sat, clamped value}.
- Single module, no sub-modules. The datapath (one adder, two shifters) is small enough to stay inline.

## Test plan

- Basic product: A_WIDTH/B_WIDTH/OUT_WIDTH defaults, din_a=3, din_b=5 → after 9 cycles dout=15, dout_sat=0, dout_valid held until dout_ready.
- Saturation: din_a=0xFFFF_FFFF, din_b=2 → dout=0xFFFF_FFFF, dout_sat=1.
- Exact fit: din_a=0x0100_0000, din_b=0xFF → dout=0xFF00_0000, dout_sat=0.
- Zero multiplier: din_b=0, din_a=0x1234 → dout=0, dout_sat=0, latency unchanged at 9.
- Backpressure and ignored inputs: hold dout_ready=0 for 5 cycles after dout_valid, and drive new din_valid during BUSY/DONE → dout stable, din_ready=0, second operand accepted only after the output handshake.
- Reset mid-operation: assert reset in BUSY cycle 4 → next cycle IDLE, dout_valid=0, dout=0; a new op din_a=7, din_b=6 then yields 42.
